// File: rtl/regfile_writeback_pkg.sv
// Shared pipeline types for the register file, the load-use interlock and
// the forwarding unit that consumes the ID operand data.
package regfile_writeback_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int PERF_W = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [PERF_W-1:0] perf_cnt_t;

  // One operand is blocked when ID really reads it and EX holds a load aimed at it.
  function automatic logic operand_hazard(input logic      use_op,
                                          input logic      ex_load,
                                          input reg_addr_t id_addr,
                                          input reg_addr_t ex_addr);
    return use_op & ex_load & (id_addr == ex_addr);
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// WB commit bus, ID operand read ports and EX interlock signals between the
// pipeline (master) and the register file / interlock block (slave).
interface regfile_writeback_if;
  import regfile_writeback_pkg::*;

  reg_data_t WB_data_write;
  reg_addr_t WB_addr_write;
  logic      WB_sig_write;

  reg_addr_t ID_addr_a;
  reg_addr_t ID_addr_b;
  logic      ID_use_a;
  logic      ID_use_b;
  reg_data_t ID_data_a;
  reg_data_t ID_data_b;

  logic      EX_load;
  reg_addr_t EX_addr_write;

  logic      ID_stall;
  logic      EX_bubble;
  perf_cnt_t stall_count;

  modport master (
    output WB_data_write, WB_addr_write, WB_sig_write,
    output ID_addr_a, ID_addr_b, ID_use_a, ID_use_b,
    output EX_load, EX_addr_write,
    input  ID_data_a, ID_data_b, ID_stall, EX_bubble, stall_count
  );

  modport slave (
    input  WB_data_write, WB_addr_write, WB_sig_write,
    input  ID_addr_a, ID_addr_b, ID_use_a, ID_use_b,
    input  EX_load, EX_addr_write,
    output ID_data_a, ID_data_b, ID_stall, EX_bubble, stall_count
  );

endinterface

// File: rtl/regfile_writeback_load_use_detect.sv
// Load-use interlock: the only hazard forwarding cannot cover, since the load
// data does not exist yet while the load is still in EX.
module load_use_detect
  import regfile_writeback_pkg::*;
(
  input  logic      id_use_a,
  input  logic      id_use_b,
  input  reg_addr_t id_addr_a,
  input  reg_addr_t id_addr_b,
  input  logic      ex_load,
  input  reg_addr_t ex_addr_write,
  output logic      id_stall
);

  logic hz_a;
  logic hz_b;

  assign hz_a     = operand_hazard(id_use_a, ex_load, id_addr_a, ex_addr_write);
  assign hz_b     = operand_hazard(id_use_b, ex_load, id_addr_b, ex_addr_write);
  assign id_stall = hz_a | hz_b;

endmodule

// File: rtl/regfile_writeback.sv
// Architectural register file written by WB and read by ID with same-cycle
// write-through, plus the load-use interlock, EX bubble and stall counter.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  regfile_writeback_if.slave bus
);

  reg_data_t regs [NREGS];
  logic      stall;
  logic      bubble_q;
  perf_cnt_t stall_count_q;

  load_use_detect u_load_use_detect (
    .id_use_a      (bus.ID_use_a),
    .id_use_b      (bus.ID_use_b),
    .id_addr_a     (bus.ID_addr_a),
    .id_addr_b     (bus.ID_addr_b),
    .ex_load       (bus.EX_load),
    .ex_addr_write (bus.EX_addr_write),
    .id_stall      (stall)
  );

  // Commit the WB result; a stall never holds back a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WB_sig_write) begin
      regs[bus.WB_addr_write] <= bus.WB_data_write;
    end
  end

  // Asynchronous reads; a write landing this cycle is passed straight through.
  always_comb begin
    bus.ID_data_a = regs[bus.ID_addr_a];
    bus.ID_data_b = regs[bus.ID_addr_b];
    if (bus.WB_sig_write && (bus.ID_addr_a == bus.WB_addr_write)) begin
      bus.ID_data_a = bus.WB_data_write;
    end
    if (bus.WB_sig_write && (bus.ID_addr_b == bus.WB_addr_write)) begin
      bus.ID_data_b = bus.WB_data_write;
    end
  end

  // Turn a stall into an EX bubble next cycle and count stalled cycles without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      bubble_q <= stall;
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign bus.ID_stall    = stall;
  assign bus.EX_bubble   = bubble_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random pipeline traffic
// compared against a plain array/counter model of the register file.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_regs [4];
  logic        m_bubble;
  int unsigned m_count;
  logic        prev_stall;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_bubble   = 1'b0;
    m_count    = 0;
    prev_stall = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a, input logic we,
                                            input logic [1:0] wa, input logic [7:0] wd);
    if (we && (a == wa)) return wd;
    return m_regs[a];
  endfunction

  // One pipeline cycle: drive at negedge, check reads/stall, then state after posedge.
  task automatic apply_stimulus(input string tag, input logic we, input logic [1:0] wa,
                                input logic [7:0] wd, input logic [1:0] aa,
                                input logic [1:0] ab, input logic ua, input logic ub,
                                input logic exl, input logic [1:0] exa);
    logic exp_stall;
    @(negedge clk);
    bus.WB_sig_write  = we;
    bus.WB_addr_write = wa;
    bus.WB_data_write = wd;
    bus.ID_addr_a     = aa;
    bus.ID_addr_b     = ab;
    bus.ID_use_a      = ua;
    bus.ID_use_b      = ub;
    bus.EX_load       = exl;
    bus.EX_addr_write = exa;
    #1;
    exp_stall = exl && ((ua && (aa == exa)) || (ub && (ab == exa)));
    check_output({tag, "_data_a"}, 32'(bus.ID_data_a), 32'(model_read(aa, we, wa, wd)));
    check_output({tag, "_data_b"}, 32'(bus.ID_data_b), 32'(model_read(ab, we, wa, wd)));
    check_output({tag, "_stall"}, 32'(bus.ID_stall), 32'(exp_stall));
    check_output({tag, "_back_to_back"}, 32'(prev_stall & bus.ID_stall), 32'd0);
    prev_stall = bus.ID_stall;
    @(posedge clk);
    if (we) m_regs[wa] = wd;
    m_bubble = exp_stall;
    if (exp_stall && (m_count < 32'hFFFF)) m_count++;
    #1;
    check_output({tag, "_bubble"}, 32'(bus.EX_bubble), 32'(m_bubble));
    check_output({tag, "_count"}, 32'(bus.stall_count), m_count);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.WB_sig_write  = 1'b0;
    bus.WB_addr_write = '0;
    bus.WB_data_write = '0;
    bus.ID_addr_a     = '0;
    bus.ID_addr_b     = '0;
    bus.ID_use_a      = 1'b0;
    bus.ID_use_b      = 1'b0;
    bus.EX_load       = 1'b0;
    bus.EX_addr_write = '0;
    model_reset();
    #2;
    check_output("por_data_a", 32'(bus.ID_data_a), 32'h00);
    check_output("por_bubble", 32'(bus.EX_bubble), 32'd0);
    check_output("por_count", 32'(bus.stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write r2 then read it back next cycle; r1 untouched.
    apply_stimulus("wr_r2", 1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply_stimulus("rd_r2", 1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
    check_output("rd_r2_lit", 32'(bus.ID_data_a), 32'hA5);
    check_output("rd_r1_lit", 32'(bus.ID_data_b), 32'h00);

    // Write-through to both ports in the write cycle.
    apply_stimulus("wt_r3", 1'b1, 2'd3, 8'h3C, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0);

    // Load-use on operand b, then the bubble cycle.
    apply_stimulus("lu_stall", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1);
    check_output("lu_bubble_lit", 32'(bus.EX_bubble), 32'd1);
    check_output("lu_count_lit", 32'(bus.stall_count), 32'd1);
    apply_stimulus("lu_release", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1);
    check_output("lu_release_lit", 32'(bus.EX_bubble), 32'd0);

    // No false stall: operand unused, or no load in EX.
    apply_stimulus("nf_unused", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1);
    apply_stimulus("nf_noload", 1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
    check_output("nf_bubble_lit", 32'(bus.EX_bubble), 32'd0);

    // Write during a stall still commits.
    apply_stimulus("wr_in_stall", 1'b1, 2'd0, 8'h5A, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 2'd2);
    apply_stimulus("rd_after", 1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0);

    // Random traffic; a load never follows a bubble, as in the real pipeline.
    for (int n = 0; n < 300; n++) begin
      logic rexl;
      rexl = m_bubble ? 1'b0 : ($urandom_range(0, 2) == 0);
      apply_stimulus("rand", 1'($urandom), 2'($urandom), 8'($urandom), 2'($urandom),
                     2'($urandom), 1'($urandom), 1'($urandom), rexl, 2'($urandom));
    end

    // Asynchronous reset in the middle of a stall with nonzero registers.
    apply_stimulus("pre_rst_wr", 1'b1, 2'd3, 8'hC3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply_stimulus("pre_rst_st", 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    bus.WB_sig_write = 1'b0;
    bus.EX_load      = 1'b0;
    bus.ID_addr_a    = 2'd3;
    bus.ID_addr_b    = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("rst_data_a", 32'(bus.ID_data_a), 32'h00);
    check_output("rst_data_b", 32'(bus.ID_data_b), 32'h00);
    check_output("rst_bubble", 32'(bus.EX_bubble), 32'd0);
    check_output("rst_count", 32'(bus.stall_count), 32'd0);

    // Walk the counter up to 0xFFFE by holding the load-use condition.
    @(negedge clk);
    rst_n            = 1'b1;
    bus.ID_addr_a    = 2'd0;
    bus.ID_use_a     = 1'b1;
    bus.EX_load      = 1'b1;
    bus.EX_addr_write= 2'd0;
    repeat (65534) @(posedge clk);
    #1;
    m_count    = 32'hFFFE;
    m_bubble   = 1'b1;
    prev_stall = 1'b1;
    check_output("sat_prefill", 32'(bus.stall_count), 32'hFFFE);
    apply_stimulus("sat_gap1", 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    apply_stimulus("sat_hit", 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0);
    check_output("sat_full", 32'(bus.stall_count), 32'hFFFF);
    apply_stimulus("sat_gap2", 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    apply_stimulus("sat_hold", 1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1);
    check_output("sat_hold_lit", 32'(bus.stall_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
